// File: rtl/div_pkg.sv
// Shared definitions for the divider blocks: checker FSM states, error codes
// and the duty-cycle acceptance rule.
package div_pkg;

   typedef enum logic [1:0] {
      StWaitRise = 2'd0,
      StMeasHigh = 2'd1,
      StMeasLow  = 2'd2
   } div_state_e;

   typedef enum logic [1:0] {
      ErrNone    = 2'd0,
      ErrPeriod  = 2'd1,
      ErrDuty    = 2'd2,
      ErrTimeout = 2'd3
   } div_err_e;

   // Odd ratios accept either neighbour of the exact half period.
   function automatic logic duty_ok(input int unsigned high, input int unsigned div);
      return (high == div / 2) || (high == (div + 1) / 2);
   endfunction

endpackage

// File: rtl/div_clk_checker_edge_det.sv
// Edge detector for a clk-synchronous signal sampled as data.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   output logic rise,
   output logic fall
);

   logic clk_d;

   // Reset high so a clk_in already high at reset release is not seen as a rise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_d <= 1'b1;
      end else begin
         clk_d <= clk_in;
      end
   end

   assign rise = clk_in & ~clk_d;
   assign fall = ~clk_in & clk_d;

endmodule

// File: rtl/div_clk_checker.sv
// Measures period and high time of a divided clock, flags period/duty/timeout
// faults, counts errors and reports lock after consecutive good periods.
module div_clk_checker
   import div_pkg::*;
#(
   parameter int unsigned DIV_N  = 8,
   parameter int unsigned LOCK_N = 2,
   localparam int unsigned W     = $clog2(2 * DIV_N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clk_in,
   output logic         meas_vld,
   output logic [W-1:0] period,
   output logic [W-1:0] high_len,
   output logic         err,
   output logic [1:0]   err_code,
   output logic [7:0]   err_cnt,
   output logic         locked
);

   localparam int unsigned GW = $clog2(LOCK_N + 1);
   localparam logic [W-1:0]  MaxCnt = W'(2 * DIV_N);
   localparam logic [GW-1:0] LockCnt = GW'(LOCK_N);

   logic rise, fall;

   div_state_e  state_q, state_d;
   logic [W-1:0] run_cnt_q, run_cnt_d, run_inc;
   logic [W-1:0] high_int_q, high_int_d;
   logic [GW-1:0] good_cnt_q, good_cnt_d;
   logic         meas_vld_q, meas_vld_d;
   logic [W-1:0] period_q, period_d;
   logic [W-1:0] high_len_q, high_len_d;
   logic         err_q, err_d;
   div_err_e     err_code_q, err_code_d, fault;
   logic [7:0]   err_cnt_q, err_cnt_d;
   logic         locked_q, locked_d;

   edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .clk_in (clk_in),
      .rise   (rise),
      .fall   (fall)
   );

   assign run_inc = (run_cnt_q == MaxCnt) ? MaxCnt : run_cnt_q + W'(1);

   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt_q;
      high_int_d = high_int_q;
      good_cnt_d = good_cnt_q;
      meas_vld_d = 1'b0;
      period_d   = period_q;
      high_len_d = high_len_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      err_cnt_d  = err_cnt_q;
      fault      = ErrNone;

      if (!en) begin
         state_d    = StWaitRise;
         run_cnt_d  = '0;
         good_cnt_d = '0;
      end else begin
         unique case (state_q)
            StWaitRise: begin
               if (rise) begin
                  state_d   = StMeasHigh;
                  run_cnt_d = W'(1);
               end
            end
            StMeasHigh: begin
               if (fall) begin
                  high_int_d = run_cnt_q;
                  run_cnt_d  = run_inc;
                  state_d    = StMeasLow;
               end else if (run_cnt_q == MaxCnt) begin
                  fault = ErrTimeout;
               end else begin
                  run_cnt_d = run_inc;
               end
            end
            StMeasLow: begin
               if (rise) begin
                  meas_vld_d = 1'b1;
                  period_d   = run_cnt_q;
                  high_len_d = high_int_q;
                  run_cnt_d  = W'(1);
                  state_d    = StMeasHigh;
                  if (run_cnt_q != W'(DIV_N)) begin
                     fault = ErrPeriod;
                  end else if (!duty_ok(32'(high_int_q), DIV_N)) begin
                     fault = ErrDuty;
                  end
               end else if (run_cnt_q == MaxCnt) begin
                  fault = ErrTimeout;
               end else begin
                  run_cnt_d = run_inc;
               end
            end
            default: state_d = StWaitRise;
         endcase

         if (fault == ErrTimeout) begin
            state_d   = StWaitRise;
            run_cnt_d = '0;
         end

         if (fault != ErrNone) begin
            err_d      = 1'b1;
            err_code_d = fault;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            good_cnt_d = '0;
         end else if (meas_vld_d && good_cnt_q != LockCnt) begin
            good_cnt_d = good_cnt_q + GW'(1);
         end
      end

      locked_d = (good_cnt_d == LockCnt);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StWaitRise;
         run_cnt_q  <= '0;
         high_int_q <= '0;
         good_cnt_q <= '0;
         meas_vld_q <= 1'b0;
         period_q   <= '0;
         high_len_q <= '0;
         err_q      <= 1'b0;
         err_code_q <= ErrNone;
         err_cnt_q  <= '0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         high_int_q <= high_int_d;
         good_cnt_q <= good_cnt_d;
         meas_vld_q <= meas_vld_d;
         period_q   <= period_d;
         high_len_q <= high_len_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_cnt_q  <= err_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign meas_vld = meas_vld_q;
   assign period   = period_q;
   assign high_len = high_len_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign err_cnt  = err_cnt_q;
   assign locked   = locked_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Randomized scoreboard bench for div_clk_checker (DIV_N=8, LOCK_N=2) with a
// timestamp-based reference model of edges, periods and error counting.
module tb_div_clk_checker;

   localparam int DIV_N  = 8;
   localparam int LOCK_N = 2;
   localparam int W      = $clog2(2 * DIV_N + 1);

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         clk_in = 1'b0;
   logic         meas_vld;
   logic [W-1:0] period;
   logic [W-1:0] high_len;
   logic         err;
   logic [1:0]   err_code;
   logic [7:0]   err_cnt;
   logic         locked;

   div_clk_checker #(
      .DIV_N  (DIV_N),
      .LOCK_N (LOCK_N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clk_in   (clk_in),
      .meas_vld (meas_vld),
      .period   (period),
      .high_len (high_len),
      .err      (err),
      .err_code (err_code),
      .err_cnt  (err_cnt),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   typedef struct {
      int due;
      bit meas;
      bit err;
      int code;
      int period;
      int high;
      int ecnt;
      bit locked;
   } exp_t;

   exp_t sb[$];

   // Reference model: tracks the time of the last rise and fall and derives
   // period/high time from timestamp differences.
   bit m_prev = 1'b1;
   bit m_armed = 1'b0;
   bit m_fell = 1'b0;
   int m_t0 = 0;
   int m_tf = 0;
   int m_good = 0;
   int m_errcnt = 0;
   int m_code = 0;
   int m_period = 0;
   int m_high = 0;

   task automatic push(input bit is_meas, input int code);
      exp_t e;
      if (code != 0) begin
         m_code = code;
         m_good = 0;
         if (m_errcnt < 255) m_errcnt++;
      end else if (m_good < LOCK_N) begin
         m_good++;
      end
      e.due    = cyc + 1;
      e.meas   = is_meas;
      e.err    = (code != 0);
      e.code   = m_code;
      e.period = m_period;
      e.high   = m_high;
      e.ecnt   = m_errcnt;
      e.locked = (m_good == LOCK_N);
      sb.push_back(e);
   endtask

   task automatic model(input bit in_v, input bit en_v, input bit rst_v);
      bit rise_v, fall_v;
      int age, code;
      if (!rst_v) begin
         m_prev = 1'b1; m_armed = 1'b0; m_good = 0; m_errcnt = 0;
         m_code = 0; m_period = 0; m_high = 0;
         return;
      end
      rise_v = in_v && !m_prev;
      fall_v = !in_v && m_prev;
      m_prev = in_v;
      if (!en_v) begin
         m_armed = 1'b0;
         m_good = 0;
         return;
      end
      if (!m_armed) begin
         if (rise_v) begin
            m_armed = 1'b1; m_fell = 1'b0; m_t0 = cyc;
         end
         return;
      end
      age = cyc - m_t0;
      if (age > 2 * DIV_N) age = 2 * DIV_N;
      if (!m_fell) begin
         if (fall_v) begin
            m_fell = 1'b1; m_tf = cyc;
         end else if (age == 2 * DIV_N) begin
            m_armed = 1'b0;
            push(1'b0, 3);
         end
      end else if (rise_v) begin
         m_period = age;
         m_high = m_tf - m_t0;
         if (m_period != DIV_N) code = 1;
         else if (m_high != DIV_N / 2 && m_high != (DIV_N + 1) / 2) code = 2;
         else code = 0;
         push(1'b1, code);
         m_t0 = cyc;
         m_fell = 1'b0;
      end else if (age == 2 * DIV_N) begin
         m_armed = 1'b0;
         push(1'b0, 3);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports something.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (meas_vld || err) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output meas_vld=%0b err=%0b code=%0d required no event (cycle %0d)",
                        meas_vld, err, err_code, cyc);
            end else begin
               e = sb.pop_front();
               check("event_cycle", cyc, e.due);
               check("meas_vld", int'(meas_vld), int'(e.meas));
               check("err", int'(err), int'(e.err));
               check("err_code", int'(err_code), e.code);
               check("period", int'(period), e.period);
               check("high_len", int'(high_len), e.high);
               check("err_cnt", int'(err_cnt), e.ecnt);
               check("locked", int'(locked), int'(e.locked));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event meas_vld=0 err=0 required meas=%0b err=%0b due=%0d (cycle %0d)",
                     e.meas, e.err, e.due, cyc);
         end
      end
   end

   bit g_en = 1'b1;
   bit g_rst_force = 1'b1;
   bit g_rnd_rst = 1'b0;
   bit chk_rst = 1'b0;

   task automatic step(input bit in_v);
      bit r_v;
      @(negedge clk);
      if (chk_rst) begin
         chk_rst = 1'b0;
         check("rst_meas_vld", int'(meas_vld), 0);
         check("rst_period", int'(period), 0);
         check("rst_high_len", int'(high_len), 0);
         check("rst_err", int'(err), 0);
         check("rst_err_code", int'(err_code), 0);
         check("rst_err_cnt", int'(err_cnt), 0);
         check("rst_locked", int'(locked), 0);
      end
      r_v = 1'b1;
      if (g_rst_force) r_v = 1'b0;
      else if (g_rnd_rst && $urandom_range(0, 299) == 0) r_v = 1'b0;
      clk_in = in_v;
      en = g_en;
      rst = r_v;
      model(in_v, g_en, r_v);
      if (!r_v) chk_rst = 1'b1;
   endtask

   task automatic wave(input int h, input int l);
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
   endtask

   initial begin
      int r, h, l;
      for (int i = 0; i < 3; i++) step(1'b0);
      g_rst_force = 1'b0;

      // Clean clock, then duty fault, period fault and stuck-low timeout.
      for (int i = 0; i < 10; i++) wave(4, 4);
      wave(5, 3);
      for (int i = 0; i < 4; i++) wave(4, 4);
      wave(5, 4);
      for (int i = 0; i < 4; i++) wave(4, 4);
      wave(4, 24);
      for (int i = 0; i < 4; i++) wave(4, 4);

      // One-cycle reset in the low phase while clk_in rises.
      wave(4, 2);
      g_rst_force = 1'b1;
      step(1'b1);
      g_rst_force = 1'b0;
      wave(3, 4);
      for (int i = 0; i < 5; i++) wave(4, 4);

      // Randomized periods, enable drops and occasional resets.
      g_rnd_rst = 1'b1;
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 11);
         h = 4;
         l = 4;
         case (r)
            6: begin h = 5; l = 3; end
            7: begin h = 5; l = 4; end
            8: begin h = $urandom_range(1, 12); l = $urandom_range(1, 12); end
            9: begin h = 4; l = $urandom_range(12, 22); end
            10: begin h = $urandom_range(12, 22); l = 3; end
            default: ;
         endcase
         g_en = ($urandom_range(0, 19) != 0);
         wave(h, l);
         g_en = 1'b1;
      end
      g_rnd_rst = 1'b0;

      // Timeout storm saturates err_cnt; then enable low suppresses events.
      for (int i = 0; i < 300; i++) wave(1, 17);
      step(1'b0);
      step(1'b0);
      check("err_cnt_saturated", int'(err_cnt), m_errcnt);
      check("err_cnt_at_255", m_errcnt, 255);
      g_en = 1'b0;
      for (int i = 0; i < 20; i++) wave(1, 17);
      for (int i = 0; i < 5; i++) wave(4, 4);
      check("err_cnt_held", int'(err_cnt), 255);

      for (int i = 0; i < 4; i++) step(1'b0);
      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_clk_checker.md
DIV_CLK_CHECKER -- requirements
Module: div_clk_checker

Interface
REQ-001 Parameter DIV_N, default 8: expected division ratio of the monitored clock (integer, 2..127).
REQ-002 Parameter LOCK_N, default 2: consecutive good periods required to assert locked.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-low.
REQ-005 en  input  1  measurement enable; 0 holds checker idle.
REQ-006 clk_in  input  1  divided clock under test, synchronous to clk, sampled as data.
REQ-007 meas_vld  output  1  one-cycle pulse: new period/high_len valid.
REQ-008 period  output  W  last measured period in clk cycles; W = clog2(2*DIV_N+1).
REQ-009 high_len  output  W  last measured high time in clk cycles.
REQ-010 err  output  1  one-cycle pulse on any detected fault.
REQ-011 err_code  output  2  0 none, 1 period mismatch, 2 duty mismatch, 3 timeout; valid with err, held until next err.
REQ-012 err_cnt  output  8  total errors since reset, saturating at 255.
REQ-013 locked  output  1  level: LOCK_N consecutive good periods seen, no error since.

Function
REQ-014 Edge detect SHALL use registered copy clk_d: rise = clk_in & ~clk_d, fall = ~clk_in & clk_d.
REQ-015 FSM states SHALL be WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-016 WAIT_RISE: on rise -> MEAS_HIGH, run_cnt <= 1, no measurement reported.
REQ-017 In MEAS states run_cnt SHALL increment by 1 per cycle, saturating at 2*DIV_N.
REQ-018 MEAS_HIGH: on fall -> capture high_len_int = run_cnt, go MEAS_LOW.
REQ-019 MEAS_LOW: on rise -> period <= run_cnt, high_len <= high_len_int, meas_vld = 1 next cycle, run_cnt <= 1, go MEAS_HIGH.
REQ-020 Check at each reported measurement: period != DIV_N -> err, code 1; else high_len not in {floor(DIV_N/2), ceil(DIV_N/2)} -> err, code 2; code 1 has priority.
REQ-021 Timeout: in MEAS_HIGH or MEAS_LOW, run_cnt == 2*DIV_N with no qualifying edge that cycle -> err, code 3, go WAIT_RISE, no meas_vld.
REQ-022 err SHALL assert in the same cycle as the associated meas_vld (period/duty) or one cycle after the timeout condition.
REQ-023 good_cnt SHALL increment on each error-free measurement, saturating at LOCK_N; locked = 1 when good_cnt == LOCK_N.
REQ-024 Any err SHALL clear good_cnt and locked in the same cycle err asserts.
REQ-025 err_cnt SHALL increment by 1 per err pulse, hold at 255.
REQ-026 en = 0: state -> WAIT_RISE, good_cnt/locked cleared, no meas_vld/err; period, high_len, err_code, err_cnt hold; clk_d keeps tracking clk_in.
REQ-027 Timing example DIV_N=8: rise detected cycle 0, fall cycle 4 -> high_len 4; next rise cycle 8 -> period 8.

Reset
REQ-028 On rst = 0 at posedge clk: state WAIT_RISE, run_cnt 0, good_cnt 0, clk_d 1, meas_vld 0, period 0, high_len 0, err 0, err_code 0, err_cnt 0, locked 0.
REQ-029 clk_d reset value 1 SHALL prevent a spurious rise when clk_in is high at reset release.
REQ-030 Reset mid-measurement SHALL discard the partial period; no meas_vld until one full period after the next rise.

Structure
REQ-031 State encodings and err_code constants SHALL live in the shared div package/header used by the divider blocks.
REQ-032 One sub-module edge_det (clk_d register, rise/fall outputs) SHALL be instantiated; remaining logic in div_clk_checker.
REQ-033 All outputs SHALL be registered.

Verification (DIV_N=8, LOCK_N=2)
REQ-034 Clean 4-high/4-low clk_in after reset -> meas_vld every 8 cycles, period 8, high_len 4, locked after 2nd meas_vld, err never.
REQ-035 One period 5-high/3-low -> period 8, high_len 5, err, code 2, locked drops; relocks after 2 good periods.
REQ-036 One period 5-high/4-low -> period 9, err, code 1, err_cnt +1.
REQ-037 clk_in stuck low after lock -> err, code 3 when run_cnt reaches 16, state WAIT_RISE, locked 0.
REQ-038 rst low for 1 cycle during MEAS_LOW with clk_in high -> all outputs reset values, no spurious rise, first meas_vld one full period after the next rise.
REQ-039 300 consecutive timeouts -> err_cnt saturates at 255; en = 0 mid-stream -> no further err/meas_vld.
